// File: rtl/instr_fetch_if.sv
// Fetch unit bundle: instruction-memory request/response, decode handshake, redirect and halt status.
// The master side is the fetch unit; the slave side is the memory/decode/execute environment.
interface instr_fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            halted;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: single-outstanding imem reads, one-entry hold buffer to decode; rvalid->instr_valid 1 cycle.
// Backpressure: the held entry stays stable until instr_ready; redirects flush and restart at redirect_pc.
module instr_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] w_instr_nxt;
    logic [XLEN-1:0] r_instr_pc;
    logic [XLEN-1:0] w_instr_pc_nxt;
    logic            r_discard;
    logic            w_discard_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_discard  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_discard  <= w_discard_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_discard_nxt  = r_discard;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (bus.redirect) begin
                    w_pc_nxt = bus.redirect_pc;
                end
                // A grant in the redirect cycle already launched the stale address.
                if (bus.imem_gnt) begin
                    w_state_nxt   = S_WAIT;
                    w_discard_nxt = bus.redirect;
                end
            end
            S_WAIT: begin
                if (bus.redirect) begin
                    w_pc_nxt = bus.redirect_pc;
                    if (bus.imem_rvalid) begin
                        w_state_nxt   = S_FETCH;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_discard_nxt = 1'b1;
                    end
                end else if (bus.imem_rvalid) begin
                    if (r_discard) begin
                        w_state_nxt   = S_FETCH;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_instr_nxt    = bus.imem_rdata;
                        w_instr_pc_nxt = r_pc;
                        w_pc_nxt       = r_pc + XLEN'(PC_STEP);
                        w_state_nxt    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // Redirect outranks the handshake, so a flushed halt opcode never halts.
                if (bus.redirect) begin
                    w_pc_nxt    = bus.redirect_pc;
                    w_state_nxt = S_FETCH;
                end else if (bus.instr_ready) begin
                    w_state_nxt = (r_instr[6:0] == 7'h7f) ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                if (bus.redirect) begin
                    w_pc_nxt    = bus.redirect_pc;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.imem_req    = (r_state == S_FETCH);
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = (r_state == S_HOLD);
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.halted      = (r_state == S_HALT);
endmodule
